// File: rtl/dmem_pkg.sv
// Shared types and constants for the line-wide data memory arbiter.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 256;

  localparam logic REQ_DCACHE = 1'b0;
  localparam logic REQ_ICACHE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the D-cache
// (requester 0) and the I-cache (requester 1); commands are latched at grant.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no transaction; sample requests, resolve ties with last_q
// ST_GRANT0 | D-cache transaction in flight, wait for mem_ack_i
// ST_GRANT1 | I-cache transaction in flight, wait for mem_ack_i
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int          ADDR_W      = DMEM_ADDR_W,
  parameter int          DATA_W      = DMEM_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              r0_enable_i,
  input  logic              r0_write_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [DATA_W-1:0] r0_data_i,
  output logic              r0_ack_o,
  output logic [DATA_W-1:0] r0_data_o,
  input  logic              r1_enable_i,
  input  logic              r1_write_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [DATA_W-1:0] r1_data_i,
  output logic              r1_ack_o,
  output logic [DATA_W-1:0] r1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              busy_o,
  output logic              err_o
);

  // Counter is wide enough to pass TIMEOUT_CYC before it saturates.
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_HIT = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  arb_state_e        state_q, state_d;
  logic              last_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;

  logic grant_vld;
  logic grant_id;
  logic busy;
  logic waiting;

  assign busy    = (state_q != ST_IDLE);
  assign waiting = busy && !mem_ack_i;

  always_comb begin
    state_d   = state_q;
    grant_vld = 1'b0;
    grant_id  = REQ_DCACHE;
    case (state_q)
      ST_IDLE: begin
        if (r0_enable_i && r1_enable_i) begin
          grant_vld = 1'b1;
          grant_id  = ~last_q;
        end else if (r0_enable_i) begin
          grant_vld = 1'b1;
          grant_id  = REQ_DCACHE;
        end else if (r1_enable_i) begin
          grant_vld = 1'b1;
          grant_id  = REQ_ICACHE;
        end
        if (grant_vld) begin
          state_d = (grant_id == REQ_ICACHE) ? ST_GRANT1 : ST_GRANT0;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (mem_ack_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= REQ_ICACHE;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_vld) begin
        last_q  <= grant_id;
        write_q <= (grant_id == REQ_ICACHE) ? r1_write_i : r0_write_i;
        addr_q  <= (grant_id == REQ_ICACHE) ? r1_addr_i  : r0_addr_i;
        data_q  <= (grant_id == REQ_ICACHE) ? r1_data_i  : r0_data_i;
        cnt_q   <= '0;
      end else if (waiting && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // Sets on the edge where the wait count reaches TIMEOUT_CYC.
      if ((TIMEOUT_CYC != 0) && waiting && (cnt_q == CNT_HIT)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mem_enable_o = busy;
  assign mem_write_o  = write_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = data_q;

  assign r0_ack_o  = mem_ack_i && (state_q == ST_GRANT0);
  assign r1_ack_o  = mem_ack_i && (state_q == ST_GRANT1);
  assign r0_data_o = mem_data_i;
  assign r1_data_o = mem_data_i;

  assign busy_o = busy;
  assign err_o  = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed stimulus queues expected grants
// and acks, a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 256;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          r0_enable_i, r0_write_i, r1_enable_i, r1_write_i;
  logic [AW-1:0] r0_addr_i, r1_addr_i;
  logic [DW-1:0] r0_data_i, r1_data_i;
  logic          r0_ack_o, r1_ack_o;
  logic [DW-1:0] r0_data_o, r1_data_o;
  logic          mem_enable_o, mem_write_o, mem_ack_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o, mem_data_i;
  logic          busy_o, err_o;

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .r0_enable_i(r0_enable_i), .r0_write_i(r0_write_i), .r0_addr_i(r0_addr_i),
    .r0_data_i(r0_data_i), .r0_ack_o(r0_ack_o), .r0_data_o(r0_data_o),
    .r1_enable_i(r1_enable_i), .r1_write_i(r1_write_i), .r1_addr_i(r1_addr_i),
    .r1_data_i(r1_data_i), .r1_ack_o(r1_ack_o), .r1_data_o(r1_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } grant_t;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
  } ack_t;

  grant_t gq[$];
  ack_t   aq[$];
  grant_t g;
  ack_t   a;

  int n_cmp = 0;
  int n_mis = 0;

  logic [DW-1:0] LINE = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
  logic [DW-1:0] D0   = {8{32'hD0D0_0001}};
  logic [DW-1:0] D1   = {8{32'hD1D1_0002}};
  logic [DW-1:0] DL   = {8{32'h1A7C_4ED0}};
  int order [6] = '{0, 1, 0, 1, 0, 1};

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic wait_en(input string nm);
    for (int i = 0; i < 40; i++) begin
      if (mem_enable_o === 1'b1) return;
      tick();
    end
    chk(nm, 256'(mem_enable_o), 256'(1));
  endtask

  task automatic push_grant(input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] dt);
    grant_t e;
    e.wr = wr; e.addr = ad; e.data = dt;
    gq.push_back(e);
  endtask

  task automatic push_ack(input logic id, input logic [DW-1:0] dt);
    ack_t e;
    e.id = id; e.data = dt;
    aq.push_back(e);
  endtask

  // Monitor: a rising mem_enable_o is a grant, any requester ack a completion.
  logic en_prev = 1'b0;
  always @(negedge clk_i) begin
    if (rst_i === 1'b0) begin
      if (mem_enable_o === 1'b1 && en_prev === 1'b0) begin
        if (gq.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL grant_unexpected: got addr %0h expected no grant", mem_addr_o);
        end else begin
          g = gq.pop_front();
          chk("grant_write", 256'(mem_write_o), 256'(g.wr));
          chk("grant_addr", 256'(mem_addr_o), 256'(g.addr));
          chk("grant_data", mem_data_o, g.data);
        end
      end
      if (r0_ack_o === 1'b1 || r1_ack_o === 1'b1) begin
        if (aq.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL ack_unexpected: got r0=%0b r1=%0b expected no ack", r0_ack_o, r1_ack_o);
        end else begin
          a = aq.pop_front();
          chk("ack_r0", 256'(r0_ack_o), 256'(!a.id));
          chk("ack_r1", 256'(r1_ack_o), 256'(a.id));
          chk("ack_data", a.id ? r1_data_o : r0_data_o, a.data);
        end
      end
    end
    en_prev = mem_enable_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    r0_enable_i = 0; r0_write_i = 0; r0_addr_i = '0; r0_data_i = '0;
    r1_enable_i = 0; r1_write_i = 0; r1_addr_i = '0; r1_data_i = '0;
    mem_ack_i = 0; mem_data_i = '0;

    // reset values
    tick(); tick();
    smp();
    chk("rst_mem_enable", 256'(mem_enable_o), 256'(0));
    chk("rst_busy", 256'(busy_o), 256'(0));
    chk("rst_err", 256'(err_o), 256'(0));
    chk("rst_mem_write", 256'(mem_write_o), 256'(0));
    chk("rst_mem_addr", 256'(mem_addr_o), 256'(0));
    chk("rst_mem_data", mem_data_o, 256'(0));
    tick();
    rst_i = 1'b0;

    // stray mem ack in IDLE
    mem_ack_i = 1; mem_data_i = LINE;
    smp();
    chk("idle_ack_r0", 256'(r0_ack_o), 256'(0));
    chk("idle_ack_r1", 256'(r1_ack_o), 256'(0));
    tick();
    mem_ack_i = 0;
    smp();
    chk("idle_ack_busy", 256'(busy_o), 256'(0));

    // single read by r0
    tick();
    r0_enable_i = 1; r0_write_i = 0; r0_addr_i = 32'h0000; r0_data_i = '0;
    push_grant(1'b0, 32'h0000, '0);
    smp();
    chk("req_lat_pre", 256'(mem_enable_o), 256'(0));
    tick();
    smp();
    chk("req_lat_post", 256'(mem_enable_o), 256'(1));
    repeat (9) tick();
    push_ack(1'b0, LINE);
    mem_ack_i = 1; mem_data_i = LINE;
    smp();
    chk("single_r0_ack", 256'(r0_ack_o), 256'(1));
    chk("single_r1_ack", 256'(r1_ack_o), 256'(0));
    tick();
    mem_ack_i = 0; r0_enable_i = 0;
    smp();
    chk("single_done", 256'(busy_o), 256'(0));

    // simultaneous requests after reset: r0 wins, r1 follows after gap
    tick();
    do_reset();
    r0_enable_i = 1; r0_write_i = 1; r0_addr_i = 32'h0200; r0_data_i = D0;
    r1_enable_i = 1; r1_write_i = 0; r1_addr_i = 32'h0400; r1_data_i = D1;
    push_grant(1'b1, 32'h0200, D0);
    push_grant(1'b0, 32'h0400, D1);
    tick();
    smp();
    chk("tie_first_write", 256'(mem_write_o), 256'(1));
    chk("tie_first_addr", 256'(mem_addr_o), 256'(32'h0200));
    tick(); tick();
    push_ack(1'b0, ~LINE);
    mem_ack_i = 1; mem_data_i = ~LINE;
    tick();
    mem_ack_i = 0; r0_enable_i = 0;
    smp();
    chk("tie_gap", 256'(mem_enable_o), 256'(0));
    tick();
    smp();
    chk("tie_second_en", 256'(mem_enable_o), 256'(1));
    chk("tie_second_addr", 256'(mem_addr_o), 256'(32'h0400));
    tick();
    push_ack(1'b1, LINE);
    mem_ack_i = 1; mem_data_i = LINE;
    tick();
    mem_ack_i = 0; r1_enable_i = 0;

    // continuous dual requests: grants alternate 0,1,0,1,0,1
    r0_write_i = 1; r0_addr_i = 32'h1000; r0_data_i = D0;
    r1_write_i = 0; r1_addr_i = 32'h2000; r1_data_i = D1;
    for (int i = 0; i < 6; i++) begin
      if (order[i] == 0) push_grant(1'b1, 32'h1000, D0);
      else               push_grant(1'b0, 32'h2000, D1);
    end
    r0_enable_i = 1; r1_enable_i = 1;
    for (int i = 0; i < 6; i++) begin
      wait_en("dual_grant_wait");
      tick();
      push_ack(order[i] != 0, {8{32'(i)}});
      mem_ack_i = 1; mem_data_i = {8{32'(i)}};
      tick();
      mem_ack_i = 0;
      if (i == 5) begin
        r0_enable_i = 0; r1_enable_i = 0;
      end
    end

    // command latch: requester changes after grant are ignored
    tick();
    r0_enable_i = 1; r0_write_i = 1; r0_addr_i = 32'h0300; r0_data_i = DL;
    push_grant(1'b1, 32'h0300, DL);
    tick();
    tick(); tick();
    r0_write_i = 0; r0_addr_i = 32'h0999; r0_data_i = ~DL;
    smp();
    chk("latch_addr", 256'(mem_addr_o), 256'(32'h0300));
    chk("latch_data", mem_data_o, DL);
    chk("latch_write", 256'(mem_write_o), 256'(1));
    tick();
    smp();
    chk("latch_addr_hold", 256'(mem_addr_o), 256'(32'h0300));
    tick();
    push_ack(1'b0, D1);
    mem_ack_i = 1; mem_data_i = D1;
    tick();
    mem_ack_i = 0; r0_enable_i = 0;

    // timeout: no ack for 8 grant cycles
    tick();
    do_reset();
    r1_enable_i = 1; r1_write_i = 0; r1_addr_i = 32'h0500; r1_data_i = '0;
    push_grant(1'b0, 32'h0500, '0);
    tick();
    repeat (8) begin
      smp();
      chk("to_not_yet", 256'(err_o), 256'(0));
      tick();
    end
    smp();
    chk("to_set", 256'(err_o), 256'(1));
    repeat (3) begin
      tick();
      smp();
      chk("to_sticky", 256'(err_o), 256'(1));
      chk("to_still_busy", 256'(busy_o), 256'(1));
    end
    tick();
    push_ack(1'b1, LINE);
    mem_ack_i = 1; mem_data_i = LINE;
    tick();
    mem_ack_i = 0; r1_enable_i = 0;
    smp();
    chk("to_done_busy", 256'(busy_o), 256'(0));
    chk("to_done_err", 256'(err_o), 256'(1));

    // reset in the middle of a GRANT1 transaction
    tick();
    r1_enable_i = 1; r1_write_i = 1; r1_addr_i = 32'h0600; r1_data_i = D1;
    push_grant(1'b1, 32'h0600, D1);
    tick();
    tick();
    rst_i = 1; r1_enable_i = 0;
    tick();
    rst_i = 0;
    smp();
    chk("midrst_enable", 256'(mem_enable_o), 256'(0));
    chk("midrst_busy", 256'(busy_o), 256'(0));
    chk("midrst_err", 256'(err_o), 256'(0));
    chk("midrst_addr", 256'(mem_addr_o), 256'(0));
    tick();
    mem_ack_i = 1; mem_data_i = LINE;
    smp();
    chk("late_ack_r0", 256'(r0_ack_o), 256'(0));
    chk("late_ack_r1", 256'(r1_ack_o), 256'(0));
    tick();
    mem_ack_i = 0;
    smp();
    chk("late_ack_busy", 256'(busy_o), 256'(0));

    chk("grant_q_empty", 256'(gq.size()), 256'(0));
    chk("ack_q_empty", 256'(aq.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single 256-bit line-wide data memory port between the data cache (requester 0) and the instruction cache (requester 1). It sits between the two cache controllers and the data memory, and serialises whole-line read/write transactions. It uses round-robin priority, latches each transaction's command for its whole duration, and has a sticky ack-timeout flag for debug.

## Interface
- `ADDR_W`, 32, byte address width.
- `DATA_W`, 256, line width in bits.
- `TIMEOUT_CYC`, 64, maximum cycles from grant to `mem_ack_i` before `err_o` sets; 0 disables the check.

- `clk_i` in 1: the single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `r0_enable_i` / `r1_enable_i` in 1: request; held high until the matching ack.
- `r0_write_i` / `r1_write_i` in 1: 1 = line write, 0 = line read.
- `r0_addr_i` / `r1_addr_i` in ADDR_W: line address.
- `r0_data_i` / `r1_data_i` in DATA_W: write data.
- `r0_ack_o` / `r1_ack_o` out 1: one-cycle completion pulse.
- `r0_data_o` / `r1_data_o` out DATA_W: read data, valid while the matching ack is high.
- `mem_enable_o` out 1: memory request.
- `mem_write_o` out 1: memory write command.
- `mem_addr_o` out ADDR_W: memory address.
- `mem_data_o` out DATA_W: memory write data.
- `mem_ack_i` in 1: memory completion pulse.
- `mem_data_i` in DATA_W: memory read data.
- `busy_o` out 1: a transaction is in flight.
- `err_o` out 1: sticky flag; timeout occurred.

## Operation
- **States and transitions**
  - States are IDLE, GRANT0 and GRANT1.
  - IDLE → GRANTn when `rn_enable_i` is sampled high.
  - GRANTn → IDLE on the edge where `mem_ack_i` = 1.
- **Tie-break**
  - When both requesters are high in IDLE, the grant goes to the requester not granted last (`last_q`).
  - `last_q` resets to 1, so requester 0 wins the first tie.
  - `last_q` updates on each grant.
- **Command latching**
  - On the grant edge, `write`, `addr` and `data` of the winner are registered.
  - `mem_*_o` drive the registered values for the whole transaction.
  - Requester-side changes after grant are ignored.
- **Memory-side outputs**
  - `mem_enable_o` = 1 exactly in GRANT0/GRANT1.
  - `mem_write_o`, `mem_addr_o` and `mem_data_o` are registered values; they hold their last value in IDLE.
- **Requester-side outputs**
  - `rn_ack_o` = `mem_ack_i` AND (state == GRANTn), combinational.
  - `rn_data_o` = `mem_data_i` for both requesters; meaningful only with the ack.
- **`mem_ack_i` in IDLE** is ignored: no requester ack is produced and there is no state change.
- **Timeout**
  - A wait counter clears on grant and increments each GRANT cycle without ack.
  - When the counter reaches `TIMEOUT_CYC` (≠0), `err_o` sets and stays set until reset.
  - The transaction is not aborted.
  - The counter saturates; it never wraps.
- **`busy_o`** = (state != IDLE).
- **Reset values**
  - State IDLE; `mem_enable_o` = 0, `mem_write_o` = 0, `mem_addr_o` = 0, `mem_data_o` = 0.
  - `err_o` = 0, `busy_o` = 0, `last_q` = 1, counter = 0.
  - Acks are 0, which follows from IDLE.
- **Reset mid-transaction**
  - The transaction is abandoned and `mem_enable_o` is low from the next edge.
  - A late `mem_ack_i` is ignored.

## Timing
- A request sampled at edge k puts `mem_enable_o` high from k+1.
- Added latency: 1 cycle request→memory, 0 cycles memory ack→requester ack.
- The ack edge returns the state to IDLE, so `mem_enable_o` drops for at least one cycle between back-to-back transactions.
- The next grant can be sampled at the edge after the ack edge.
- The requester must drop `rn_enable_i` at its ack edge.
  - A still-high enable one cycle after the ack is treated as a new request.
- Requests raised during a GRANT state wait; they are never lost as long as they are held.
- Simultaneous requests in IDLE are resolved in the same cycle per `last_q`.
- With continuous dual requests, grants strictly alternate.
- Worst-case wait for a requester: one full transaction of the other requester plus 1 cycle.

## Structure
- Shared package `dmem_pkg`:
  - state enum (IDLE/GRANT0/GRANT1);
  - `ADDR_W` and `DATA_W` defaults;
  - requester index constants (`REQ_DCACHE` = 0, `REQ_ICACHE` = 1).
- No sub-module is required.
- The round-robin pick is a few lines inside `dmem_arbiter`.

## Test plan
- **Single read:** `r0_enable_i`=1, read, addr 0x0000; memory acks after 10 cycles with line 0x0000_1111_…_FFFF.
  - `mem_enable_o` goes high one cycle after the request.
  - `r0_ack_o` pulses in the same cycle as `mem_ack_i` with that data.
  - `r1_ack_o` stays 0.
- **Simultaneous after reset:** r0 write 0x0200, r1 read 0x0400.
  - r0 is granted first; `mem_write_o`=1 and `mem_addr_o`=0x0200.
  - r1 is granted at the edge after r0's ack, with a one-cycle `mem_enable_o` gap between the two.
- **Continuous dual requests, 6 transactions:** grant order is 0,1,0,1,0,1.
- **Latch check:** r0 changes `addr`/`data` two cycles after its grant; `mem_addr_o` and `mem_data_o` keep the values sampled at grant.
- **Timeout:** `TIMEOUT_CYC`=8 and the memory never acks.
  - `err_o` rises after 8 GRANT cycles and stays set.
  - A later ack still completes the transaction.
- **Reset mid-transaction:** `rst_i` pulses during GRANT1.
  - Next cycle: `mem_enable_o`=0, `busy_o`=0, `err_o`=0.
  - A subsequent `mem_ack_i` produces no requester ack.
